// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data memory: access sizes, FSM states,
// lane masks, sign-bit positions and the lane-control payload.
package lsu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned LANE_W  = 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RESP = 2'b10
  } state_e;

  // Lane masks for a lane-0 aligned access; shifted by the lane offset.
  localparam logic [LANES-1:0] BE_B = 4'b0001;
  localparam logic [LANES-1:0] BE_H = 4'b0011;
  localparam logic [LANES-1:0] BE_W = 4'b1111;

  localparam int unsigned SIGN_B = 7;
  localparam int unsigned SIGN_H = 15;

  typedef struct packed {
    logic [1:0] lo;
    size_e      size;
    logic       uns;
  } lane_ctl_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-enable generator and load extractor/extender, shared by store and load paths.
// Sub-word accesses are forced onto their natural boundary; misalign_c reports the stray bits.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lane_ctl_t          ctl,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  rword,
  output logic [LANES-1:0]   be_c,
  output logic [DATA_W-1:0]  wlanes_c,
  output logic [DATA_W-1:0]  rdata_c,
  output logic               misalign_c
);

  logic [1:0]        off;
  logic [DATA_W-1:0] shifted;

  // Lane offset and enables from size and low address bits.
  always_comb begin
    off        = 2'b00;
    be_c       = '0;
    misalign_c = 1'b0;
    case (ctl.size)
      SZ_B: begin
        off  = ctl.lo;
        be_c = BE_B << off;
      end
      SZ_H: begin
        off        = {ctl.lo[1], 1'b0};
        be_c       = BE_H << off;
        misalign_c = ctl.lo[0];
      end
      SZ_W: begin
        be_c       = BE_W;
        misalign_c = |ctl.lo;
      end
      default: ;
    endcase
  end

  assign wlanes_c = wdata << {off, 3'b000};
  assign shifted  = rword >> {off, 3'b000};

  always_comb begin
    rdata_c = '0;
    case (ctl.size)
      SZ_B:    rdata_c = {{24{~ctl.uns & shifted[SIGN_B]}}, shifted[7:0]};
      SZ_H:    rdata_c = {{16{~ctl.uns & shifted[SIGN_H]}}, shifted[15:0]};
      SZ_W:    rdata_c = shifted;
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// LSU data memory: 1-cycle store / 2-cycle load responder over a word array.
// Define LSU_DATA_MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state;
  lane_ctl_t         ld_ctl;
  logic [IDX_W-1:0]  ld_idx;

  lane_ctl_t         cur_ctl_c;
  logic [IDX_W-1:0]  cur_idx_c;
  logic [LANES-1:0]  be_c;
  logic [DATA_W-1:0] wlanes_c;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] rword_c;
  logic              misalign_c;
  logic              fault_c;
  logic              accept_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] words [DEPTH];

  // The aligner sees the live request in IDLE and the captured load in RD.
  always_comb begin
    if (state == RD) begin
      cur_ctl_c = ld_ctl;
      cur_idx_c = ld_idx;
    end else begin
      cur_ctl_c = '{lo: req_addr[1:0], size: size_e'(req_size), uns: req_unsigned};
      cur_idx_c = req_addr[ADDR_W-1:2];
    end
  end

  assign rword_c = words[SEL_W'(cur_idx_c)];

  lsu_lane_align u_align (
    .ctl        (cur_ctl_c),
    .wdata      (req_wdata),
    .rword      (rword_c),
    .be_c       (be_c),
    .wlanes_c   (wlanes_c),
    .rdata_c    (rdata_c),
    .misalign_c (misalign_c)
  );

`ifdef LSU_DATA_MEM_MISALIGN_TRAP_EN
  assign fault_c = (32'(cur_idx_c) >= DEPTH) || (cur_ctl_c.size == SZ_RSV) || misalign_c;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_c;
  assign fault_c = (32'(cur_idx_c) >= DEPTH) || (cur_ctl_c.size == SZ_RSV);
`endif

  assign req_ready = rst_n && (state == IDLE);
  assign accept_c  = req_valid && req_ready;
  assign wr_en_c   = accept_c && req_we && !fault_c;

  // Word storage: comes up holding its own index and is never touched by reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_W-1:0] word = DATA_W'(i);
    always_ff @(posedge clk) begin
      if (wr_en_c && (cur_idx_c == IDX_W'(i))) begin
        for (int b = 0; b < LANES; b++) begin
          if (be_c[b]) word[LANE_W*b +: LANE_W] <= wlanes_c[LANE_W*b +: LANE_W];
        end
      end
    end
    assign words[i] = word;
  end

  // Control FSM with registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ld_ctl     <= '0;
      ld_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (req_we) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= fault_c;
            end else begin
              state  <= RD;
              ld_ctl <= cur_ctl_c;
              ld_idx <= cur_idx_c;
            end
          end
        end
        RD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= fault_c ? '0 : rdata_c;
          resp_err   <= fault_c;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
